// File: rtl/sha256_msg_loader.sv
// sha256_msg_loader: packs a big-endian byte stream into 32-bit words, appends
// SHA-256 padding and the 64-bit bit length, and writes whole 512-bit blocks to
// data memory starting at MSG_BASE through a single registered write port.
module sha256_msg_loader #(
  parameter  int ADDR_W     = 10,
  parameter  int MSG_BASE   = 100,
  parameter  int MAX_BLOCKS = 4,
  parameter  int LEN_W      = 32,
  parameter  int CYC_W      = 15,
  localparam int NB_W       = $clog2(MAX_BLOCKS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              start_empty,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  input  logic              byte_last,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [NB_W-1:0]   nblocks,
  output logic [CYC_W-1:0]  cycles
);

  // Word index must reach 16*MAX_BLOCKS after the final length word.
  localparam int                IDX_W     = $clog2(16 * MAX_BLOCKS + 1);
  // Largest message that still leaves room for the 0x80 byte and 8 length bytes.
  localparam int                CAP_BYTES = 64 * MAX_BLOCKS - 9;
  localparam logic [LEN_W-1:0]  CAP_BITS  = LEN_W'(CAP_BYTES * 8);
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(MSG_BASE);

  typedef enum logic [2:0] {
    IDLE, ABSORB, PAD80, ZERO, LEN_HI, LEN_LO, FIN
  } state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] word_idx, idx_inc;
  logic [LEN_W-1:0] bit_len;
  logic [63:0]      len64;
  logic [1:0]       lane;       // byte position within the word being packed, MSB first
  logic [31:0]      acc;        // partially packed word
  logic [31:0]      acc_ins;    // acc with the incoming byte inserted
  logic [31:0]      acc_pad;    // acc_ins with the 0x80 marker in the following lane
  logic             accept, overflow, take, word_done;
  logic             wr_en;
  logic [31:0]      wr_data;
  state_t           pad_next;   // where to go after a padding-phase write

  assign len64    = 64'(bit_len);
  assign idx_inc  = word_idx + 1'b1;
  // Stop zero-filling once the two length words exactly close a block.
  assign pad_next = (idx_inc[3:0] == 4'd14) ? LEN_HI : ZERO;

  // Insert the incoming byte into lane 3-k, and the 0x80 marker into lane 2-k.
  always_comb begin
    acc_ins = acc | ({24'd0, byte_data} << {~lane, 3'b000});
    acc_pad = acc_ins | (32'h0000_0080 << {2'(2'd2 - lane), 3'b000});
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: every clocked register uses <= so all flops update from the same pre-edge values.
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first, so no path through the case leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = start_empty ? PAD80 : ABSORB;
      ABSORB: begin
        if (overflow)                  state_nxt = FIN;
        else if (take && byte_last)    state_nxt = (lane == 2'd3) ? PAD80 : pad_next;
      end
      PAD80:   state_nxt = pad_next;
      ZERO:    state_nxt = pad_next;
      LEN_HI:  state_nxt = LEN_LO;
      LEN_LO:  state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: byte handshake and the word to be written on the next edge.
  always_comb begin
    byte_ready = (state == ABSORB);
    accept     = byte_ready && byte_valid;
    overflow   = accept && (bit_len == CAP_BITS);
    take       = accept && !overflow;
    word_done  = take && ((lane == 2'd3) || byte_last);
    wr_en      = 1'b0;
    wr_data    = 32'd0;
    case (state)
      ABSORB: begin
        wr_en   = word_done;
        wr_data = (lane == 2'd3) ? acc_ins : acc_pad;
      end
      PAD80: begin
        wr_en   = 1'b1;
        wr_data = 32'h8000_0000;
      end
      ZERO: begin
        wr_en   = 1'b1;
        wr_data = 32'd0;
      end
      LEN_HI: begin
        wr_en   = 1'b1;
        wr_data = len64[63:32];
      end
      LEN_LO: begin
        wr_en   = 1'b1;
        wr_data = len64[31:0];
      end
      default: ;
    endcase
  end

  // Datapath: packing state, registered write port, status and cycle counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      nblocks   <= '0;
      cycles    <= '0;
      word_idx  <= '0;
      bit_len   <= '0;
      lane      <= '0;
      acc       <= '0;
    end else begin
      done   <= 1'b0;
      mem_we <= wr_en;
      if (wr_en) begin
        mem_addr  <= BASE + ADDR_W'(word_idx);
        mem_wdata <= wr_data;
        word_idx  <= idx_inc;
      end
      if (busy) cycles <= cycles + 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            err      <= 1'b0;
            nblocks  <= '0;
            cycles   <= '0;
            word_idx <= '0;
            bit_len  <= '0;
            lane     <= '0;
            acc      <= '0;
            busy     <= 1'b1;
          end
        end
        ABSORB: begin
          if (overflow) err <= 1'b1;
          if (take) begin
            bit_len <= bit_len + LEN_W'(8);
            if (word_done) begin
              acc  <= '0;
              lane <= '0;
            end else begin
              acc  <= acc_ins;
              lane <= lane + 1'b1;
            end
          end
        end
        FIN: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          nblocks <= err ? '0 : NB_W'(word_idx >> 4);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_loader.sv
// Scoreboard bench for sha256_msg_loader: stimulus pushes expected memory writes,
// per-DUT monitors pop and compare on every mem_we. A second instance with
// MAX_BLOCKS=1 covers capacity overflow.
module tb_sha256_msg_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, start_empty, byte_valid, byte_last;
  logic [7:0]  byte_data;
  bit          sel;                 // 0: drive dut0 (MAX_BLOCKS=4), 1: drive dut1 (MAX_BLOCKS=1)

  logic        rdy0, we0, busy0, done0, err0;
  logic [9:0]  addr0;
  logic [31:0] wdata0;
  logic [2:0]  nb0;
  logic [14:0] cyc0;

  logic        rdy1, we1, busy1, done1, err1;
  logic [9:0]  addr1;
  logic [31:0] wdata1;
  logic [0:0]  nb1;
  logic [14:0] cyc1;

  logic        rdy_m, done_m, err_m, busy_m;
  logic [2:0]  nb_m;

  always #5 clk = ~clk;

  sha256_msg_loader #(.ADDR_W(10), .MSG_BASE(100), .MAX_BLOCKS(4), .LEN_W(32), .CYC_W(15)) dut0 (
    .clk(clk), .reset(reset), .start(start & ~sel), .start_empty(start_empty),
    .byte_valid(byte_valid & ~sel), .byte_data(byte_data), .byte_last(byte_last),
    .byte_ready(rdy0), .mem_we(we0), .mem_addr(addr0), .mem_wdata(wdata0),
    .busy(busy0), .done(done0), .err(err0), .nblocks(nb0), .cycles(cyc0));

  sha256_msg_loader #(.ADDR_W(10), .MSG_BASE(100), .MAX_BLOCKS(1), .LEN_W(32), .CYC_W(15)) dut1 (
    .clk(clk), .reset(reset), .start(start & sel), .start_empty(start_empty),
    .byte_valid(byte_valid & sel), .byte_data(byte_data), .byte_last(byte_last),
    .byte_ready(rdy1), .mem_we(we1), .mem_addr(addr1), .mem_wdata(wdata1),
    .busy(busy1), .done(done1), .err(err1), .nblocks(nb1), .cycles(cyc1));

  assign rdy_m  = sel ? rdy1  : rdy0;
  assign done_m = sel ? done1 : done0;
  assign err_m  = sel ? err1  : err0;
  assign busy_m = sel ? busy1 : busy0;
  assign nb_m   = sel ? {2'b00, nb1} : nb0;

  typedef struct packed {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         q0[$], q1[$];
  logic [7:0]  msg_q[$];
  logic [31:0] mem0 [0:1023];
  int          wr_cnt0, wr_cnt1, max_addr1;
  int          cyc_n, last_we_cyc;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Cycle counter used to measure write-to-done spacing.
  always @(posedge clk) cyc_n++;

  // Monitor for dut0: capture the memory image and compare every write with the scoreboard.
  always @(negedge clk) begin
    wr_t e;
    if (we0) begin
      mem0[addr0] = wdata0;
      wr_cnt0++;
      last_we_cyc = cyc_n;
      if (q0.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL wr0_unexpected: got addr %0d data %h expected no write", addr0, wdata0);
      end else begin
        e = q0.pop_front();
        check("wr0_addr", 64'(addr0), 64'(e.addr));
        check("wr0_data", 64'(wdata0), 64'(e.data));
      end
    end
  end

  // Monitor for dut1 (overflow instance).
  always @(negedge clk) begin
    wr_t e;
    if (we1) begin
      wr_cnt1++;
      if (int'(addr1) > max_addr1) max_addr1 = int'(addr1);
      if (q1.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL wr1_unexpected: got addr %0d data %h expected no write", addr1, wdata1);
      end else begin
        e = q1.pop_front();
        check("wr1_addr", 64'(addr1), 64'(e.addr));
        check("wr1_data", 64'(wdata1), 64'(e.data));
      end
    end
  end

  task automatic clear_img();
    foreach (mem0[i]) mem0[i] = 32'hdead_beef;
    wr_cnt0   = 0;
    wr_cnt1   = 0;
    max_addr1 = 0;
  endtask

  task automatic load_str(input string s);
    msg_q.delete();
    for (int i = 0; i < s.len(); i++) msg_q.push_back(8'(s[i]));
  endtask

  task automatic load_fill(input int n, input logic [7:0] v);
    msg_q.delete();
    for (int i = 0; i < n; i++) msg_q.push_back(v);
  endtask

  // Reference SHA-256 padding of msg_q, pushed as expected dut0 writes from word 100.
  task automatic model_push();
    logic [7:0]  b[$];
    logic [63:0] bits;
    wr_t         e;
    b    = msg_q;
    bits = 64'(msg_q.size()) * 64'd8;
    b.push_back(8'h80);
    while (b.size() % 64 != 56) b.push_back(8'h00);
    for (int i = 7; i >= 0; i--) b.push_back(bits[8*i +: 8]);
    for (int w = 0; w < b.size() / 4; w++) begin
      e.addr = 10'(100 + w);
      e.data = {b[4*w], b[4*w+1], b[4*w+2], b[4*w+3]};
      q0.push_back(e);
    end
  endtask

  task automatic start_msg(input bit empty);
    @(posedge clk); #1;
    start       = 1'b1;
    start_empty = empty;
    @(posedge clk); #1;
    start       = 1'b0;
    start_empty = 1'b0;
  endtask

  task automatic send_bytes(input bit gaps, input bit mark_last, output int ngap);
    int t;
    ngap = 0;
    for (int i = 0; i < msg_q.size(); i++) begin
      if (gaps) begin
        for (int g = 0; g < 3 && $urandom_range(0, 1) == 1; g++) begin
          byte_valid = 1'b0;
          @(posedge clk); #1;
          ngap++;
        end
      end
      byte_valid = 1'b1;
      byte_data  = msg_q[i];
      byte_last  = mark_last && (i == msg_q.size() - 1);
      t = 0;
      while (!rdy_m && t < 50) begin
        @(posedge clk); #1;
        t++;
      end
      if (!rdy_m) begin
        bound_fail("byte_ready_wait");
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
    byte_last  = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_nb, input bit exp_err,
                           input int exp_wr, input bit chk_gap);
    int t;
    t = 0;
    while (!done_m && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (!done_m) begin
      bound_fail({name, "_done_wait"});
      return;
    end
    check({name, "_nblocks"}, 64'(nb_m), 64'(exp_nb));
    check({name, "_err"}, 64'(err_m), 64'(exp_err));
    check({name, "_busy_low"}, 64'(busy_m), 64'd0);
    check({name, "_wr_count"}, 64'(sel ? wr_cnt1 : wr_cnt0), 64'(exp_wr));
    check({name, "_pending"}, 64'(sel ? q1.size() : q0.size()), 64'd0);
    if (chk_gap) check({name, "_done_after_last_wr"}, 64'(cyc_n - last_we_cyc), 64'd1);
    @(negedge clk);
    check({name, "_done_pulse"}, 64'(done_m), 64'd0);
  endtask

  task automatic check_zero0(input string tag);
    check({tag, "_byte_ready"}, 64'(rdy0),   64'd0);
    check({tag, "_mem_we"},     64'(we0),    64'd0);
    check({tag, "_mem_addr"},   64'(addr0),  64'd0);
    check({tag, "_mem_wdata"},  64'(wdata0), 64'd0);
    check({tag, "_busy"},       64'(busy0),  64'd0);
    check({tag, "_done"},       64'(done0),  64'd0);
    check({tag, "_err"},        64'(err0),   64'd0);
    check({tag, "_nblocks"},    64'(nb0),    64'd0);
    check({tag, "_cycles"},     64'(cyc0),   64'd0);
  endtask

  initial begin
    int          g;
    logic [14:0] c_hold;
    wr_t         e;

    reset = 1'b0; start = 1'b0; start_empty = 1'b0; sel = 1'b0;
    byte_valid = 1'b0; byte_last = 1'b0; byte_data = 8'h00;
    cyc_n = 0; last_we_cyc = 0;
    clear_img();
    #12;
    check_zero0("reset");
    check("reset_busy1", 64'(busy1), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // 1: "hello world", back-to-back bytes
    clear_img();
    load_str("hello world");
    model_push();
    start_msg(1'b0);
    send_bytes(1'b0, 1'b1, g);
    wait_done("t1", 1, 1'b0, 16, 1'b1);
    check("t1_m100", 64'(mem0[100]), 64'h6865_6c6c);
    check("t1_m101", 64'(mem0[101]), 64'h6f20_776f);
    check("t1_m102", 64'(mem0[102]), 64'h726c_6480);
    for (int a = 103; a <= 114; a += 11) check($sformatf("t1_m%0d", a), 64'(mem0[a]), 64'd0);
    check("t1_m115", 64'(mem0[115]), 64'h58);
    check("t1_cycles", 64'(cyc0), 64'd25);
    c_hold = cyc0;
    repeat (3) @(negedge clk);
    check("t1_cycles_frozen", 64'(cyc0), 64'(c_hold));

    // 1b: same message with random byte_valid gaps
    clear_img();
    load_str("hello world");
    model_push();
    start_msg(1'b0);
    send_bytes(1'b1, 1'b1, g);
    wait_done("t1g", 1, 1'b0, 16, 1'b1);
    check("t1g_m102", 64'(mem0[102]), 64'h726c_6480);
    check("t1g_m115", 64'(mem0[115]), 64'h58);
    check("t1g_cycles", 64'(cyc0), 64'(25 + g));

    // 2a: 55 bytes fit in one block
    clear_img();
    load_fill(55, 8'h61);
    model_push();
    start_msg(1'b0);
    send_bytes(1'b0, 1'b1, g);
    wait_done("t2a", 1, 1'b0, 16, 1'b1);
    check("t2a_m113", 64'(mem0[113]), 64'h6161_6180);
    check("t2a_m115", 64'(mem0[115]), 64'h1b8);

    // 2b: 56 bytes spill into a second block
    clear_img();
    load_fill(56, 8'h61);
    model_push();
    start_msg(1'b0);
    send_bytes(1'b0, 1'b1, g);
    wait_done("t2b", 2, 1'b0, 32, 1'b1);
    check("t2b_m114", 64'(mem0[114]), 64'h8000_0000);
    check("t2b_m131", 64'(mem0[131]), 64'h1c0);

    // 3: 64 bytes, exact block, padding starts a new block
    clear_img();
    load_fill(64, 8'h61);
    model_push();
    start_msg(1'b0);
    send_bytes(1'b0, 1'b1, g);
    wait_done("t3", 2, 1'b0, 32, 1'b1);
    check("t3_m116", 64'(mem0[116]), 64'h8000_0000);
    check("t3_m129", 64'(mem0[129]), 64'd0);
    check("t3_m131", 64'(mem0[131]), 64'h200);

    // 4: zero-length message
    clear_img();
    msg_q.delete();
    model_push();
    start_msg(1'b1);
    wait_done("t4", 1, 1'b0, 16, 1'b1);
    check("t4_m100", 64'(mem0[100]), 64'h8000_0000);
    check("t4_m115", 64'(mem0[115]), 64'd0);

    // 5: MAX_BLOCKS=1 instance, 56 bytes overflow capacity of 55
    sel = 1'b1;
    clear_img();
    load_fill(56, 8'h61);
    for (int w = 0; w < 13; w++) begin
      e.addr = 10'(100 + w);
      e.data = 32'h6161_6161;
      q1.push_back(e);
    end
    start_msg(1'b0);
    send_bytes(1'b0, 1'b1, g);
    check("t5_err_on_56th", 64'(err1), 64'd1);
    wait_done("t5", 0, 1'b1, 13, 1'b0);
    check("t5_max_addr_le_113", 64'(max_addr1 <= 113), 64'd1);
    sel = 1'b0;

    // 6: reset during ABSORB after 6 bytes, then a clean rerun
    clear_img();
    load_str("hello ");
    e.addr = 10'd100;
    e.data = 32'h6865_6c6c;
    q0.push_back(e);
    start_msg(1'b0);
    send_bytes(1'b0, 1'b0, g);
    check("t6_busy_before_reset", 64'(busy0), 64'd1);
    #2 reset = 1'b0;
    #1 check_zero0("t6_async");
    @(negedge clk);
    reset = 1'b1;
    check("t6_pending", 64'(q0.size()), 64'd0);

    clear_img();
    load_str("hello world");
    model_push();
    start_msg(1'b0);
    send_bytes(1'b0, 1'b1, g);
    start_msg(1'b1);                       // must be ignored while busy
    wait_done("t6r", 1, 1'b0, 16, 1'b1);
    check("t6r_m102", 64'(mem0[102]), 64'h726c_6480);
    check("t6r_m115", 64'(mem0[115]), 64'h58);
    check("t6r_cycles", 64'(cyc0), 64'd25);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sha256_msg_loader.md
Name: sha256_msg_loader

Overview:
- Parametrised message-preload engine for the RV32I SHA-256 flow.
- Accepts a byte stream (valid/ready) and packs it big-endian into 32-bit words.
- Appends standard SHA-256 padding and writes 1..MAX_BLOCKS 512-bit blocks into data memory, starting at MSG_BASE, through a single write port.
- Reports block count, error status and a busy-cycle count. Replaces hand-poked message words in benches and supports multi-block messages.

Parameters:
ADDR_W, 10, data-memory word-address width
MSG_BASE, 100, word address of first message word
MAX_BLOCKS, 4, maximum 512-bit blocks written (>=1)
LEN_W, 32, width of internal bit-length counter (<=64; upper length bits zero-extended)
CYC_W, 15, width of busy-cycle counter

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begins a message when idle
start_empty  input  1  sampled with start; 1 = zero-length message
byte_valid  input  1  byte_data valid
byte_data  input  8  message byte
byte_last  input  1  qualifies final byte (with byte_valid)
byte_ready  output  1  engine accepts a byte this cycle
mem_we  output  1  data-memory write strobe
mem_addr  output  ADDR_W  word address
mem_wdata  output  32  word data
busy  output  1  high from cycle after start until done
done  output  1  one-cycle completion pulse
err  output  1  capacity overflow; sticky until next start
nblocks  output  clog2(MAX_BLOCKS+1)  blocks written; valid at done, held
cycles  output  CYC_W  busy cycles of last/current run; wraps modulo 2^CYC_W

Behaviour:
- Reset (async, reset=0): state IDLE; byte_ready, mem_we, busy, done, err = 0; mem_addr, mem_wdata, nblocks, cycles, and internal counters = 0.
- States: IDLE, ABSORB, PAD80, ZERO, LEN_HI, LEN_LO, FIN.
- IDLE:
  - start=1 clears err, nblocks, cycles, word index and bit length.
  - Next state is ABSORB, or PAD80 if start_empty=1.
  - start is ignored in every non-IDLE state.
- ABSORB:
  - byte_ready=1; a byte is accepted when byte_valid & byte_ready.
  - Each accepted byte goes to byte lane 3-k (k = byte position 0..3, MSB first); bit length += 8.
  - On the 4th byte: registered write next cycle, with mem_addr = MSG_BASE + word index; word index++.
  - Accepted byte with byte_last, word not full:
    - 0x80 goes in the next lane, remaining lanes 0.
    - That word is written; next state ZERO.
  - Accepted byte with byte_last, word full: write the word; next state PAD80.
- PAD80: write 0x80000000; next state ZERO.
- ZERO:
  - Write 0x00000000 until (word index mod 16) == 14.
  - If the 0x80 word landed at index 14 or 15 of a block, zero-fill to the end of that block and continue into the next block.
- LEN_HI: write bit_length[63:32] (0 when LEN_W <= 32).
- LEN_LO: write bit_length[31:0].
- FIN: done=1 for one cycle; nblocks = word index / 16; busy falls; return to IDLE.
- Write rate and count:
  - At most one mem_we per cycle.
  - In PAD80, ZERO and LEN states, mem_we=1 every cycle.
  - Total writes = 16*nblocks; addresses are strictly consecutive, with no gaps and no repeats.
- Overflow:
  - Capacity = 64*MAX_BLOCKS - 9 bytes.
  - A byte accepted when the byte count already equals capacity is dropped; err=1.
  - No further writes (including length); go to FIN; nblocks = 0.
- Backpressure: byte_valid gaps stall ABSORB only; no timeout.
- cycles: increments every cycle busy=1; frozen after done until next start.
- Reset mid-operation: immediate abort to reset values; a partially written memory image is not cleaned.

Test Plan:
1. "hello world" (11 bytes, back-to-back valid):
   - mem[100]=68656c6c, [101]=6f20776f, [102]=726c6480.
   - [103..113]=0, [114]=0, [115]=00000058.
   - nblocks=1, err=0, exactly 16 writes.
2. 55 bytes of 0x61:
   - 1 block; word at 113 = 61616180; [115]=000001B8.
   - 56 bytes: word 114 = 80000000, 2 blocks, 32 writes, [131]=000001C0.
3. 64 bytes of 0x61:
   - [116]=80000000; [117..129]=0; [131]=00000200; nblocks=2.
4. start with start_empty=1:
   - [100]=80000000, [101..115]=0, nblocks=1.
   - done exactly one cycle after the LEN_LO write.
5. MAX_BLOCKS=1, 56 bytes:
   - err=1 on the 56th byte; no write with address > 113; nblocks=0; done pulses.
   - Random byte_valid gaps on test 1 give an identical memory image, and cycles grows accordingly.
6. Reset low mid-ABSORB (after 6 bytes):
   - All outputs return to 0 asynchronously; a following start reruns test 1 with correct results.
   - start pulsed while busy is ignored.
